// File: rtl/shift_reg_univ_pkg.sv
// rtl/shift_reg_univ_pkg.sv - mode encodings, per-cell select codes and helpers for the universal shift register
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHR   = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_ROTR  = 3'd3,
    MODE_ROTL  = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_e;

  typedef enum logic [2:0] {
    CS_HOLD = 3'd0,
    CS_LO   = 3'd1,
    CS_HI   = 3'd2,
    CS_LOAD = 3'd3,
    CS_ZERO = 3'd4
  } cell_sel_e;

  localparam int MAX_DEPTH = 64;

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// rtl/shift_reg_univ_if.sv - control/data bundle between a driver and the universal shift register
interface shift_reg_univ_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  import shift_pkg::*;
  localparam int FILL_W = fill_w(DEPTH);

  logic                    en;
  logic [2:0]              mode;
  logic [WIDTH-1:0]        sin;
  logic [DEPTH*WIDTH-1:0]  pin;
  logic [WIDTH-1:0]        sout_r;
  logic [WIDTH-1:0]        sout_l;
  logic                    sout_r_vld;
  logic                    sout_l_vld;
  logic [DEPTH*WIDTH-1:0]  pout;
  logic [FILL_W-1:0]       fill_cnt;
  logic                    full;
  logic                    empty;
  logic                    mode_err;

  modport master (
    output en, mode, sin, pin,
    input  sout_r, sout_l, sout_r_vld, sout_l_vld, pout, fill_cnt, full, empty, mode_err
  );

  modport slave (
    input  en, mode, sin, pin,
    output sout_r, sout_l, sout_r_vld, sout_l_vld, pout, fill_cnt, full, empty, mode_err
  );

endinterface

// File: rtl/shift_reg_univ_cell.sv
// rtl/shift_reg_univ_cell.sv - one stage: data + valid flop with hold/neighbour/load/zero next-value mux
module shift_cell
  import shift_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  cell_sel_e        i_sel,
  input  logic [WIDTH-1:0] i_lo_d,
  input  logic             i_lo_v,
  input  logic [WIDTH-1:0] i_hi_d,
  input  logic             i_hi_v,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_d,
  output logic             o_v
);

  logic [WIDTH-1:0] r_d;
  logic             r_v;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_d <= '0;
      r_v <= 1'b0;
    end else begin
      case (i_sel)
        CS_LO: begin
          r_d <= i_lo_d;
          r_v <= i_lo_v;
        end
        CS_HI: begin
          r_d <= i_hi_d;
          r_v <= i_hi_v;
        end
        CS_LOAD: begin
          r_d <= i_pin;
          r_v <= 1'b1;
        end
        CS_ZERO: begin
          r_d <= '0;
          r_v <= 1'b0;
        end
        default: begin
          r_d <= r_d;
          r_v <= r_v;
        end
      endcase
    end
  end

  assign o_d = r_d;
  assign o_v = r_v;

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register (shift/rotate/load/clear) with per-stage valid tags
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             clr,
  shift_reg_univ_if.slave bus
);

  localparam int FILL_W = fill_w(DEPTH);

  cell_sel_e        w_sel;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_vld_vec [DEPTH];
  logic [DEPTH-1:0] w_vld;
  logic [WIDTH-1:0] w_edge_lo_d;
  logic             w_edge_lo_v;
  logic [WIDTH-1:0] w_edge_hi_d;
  logic             w_edge_hi_v;
  logic             r_mode_err;

  // One select drives every cell; en=0 and HOLD/RSVD all collapse to hold.
  always_comb begin
    w_sel = CS_HOLD;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_SHR, MODE_ROTR: w_sel = CS_LO;
        MODE_SHL, MODE_ROTL: w_sel = CS_HI;
        MODE_LOAD:           w_sel = CS_LOAD;
        MODE_CLEAR:          w_sel = CS_ZERO;
        default:             w_sel = CS_HOLD;
      endcase
    end
  end

  // End stages take either the serial input (new, valid) or the opposite end on rotate.
  assign w_edge_lo_d = (bus.mode == MODE_ROTR) ? w_data[DEPTH-1]    : bus.sin;
  assign w_edge_lo_v = (bus.mode == MODE_ROTR) ? w_vld_vec[DEPTH-1] : 1'b1;
  assign w_edge_hi_d = (bus.mode == MODE_ROTL) ? w_data[0]          : bus.sin;
  assign w_edge_hi_v = (bus.mode == MODE_ROTL) ? w_vld_vec[0]       : 1'b1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_lo_d;
    logic             w_lo_v;
    logic [WIDTH-1:0] w_hi_d;
    logic             w_hi_v;

    if (g == 0) begin : g_lo_edge
      assign w_lo_d = w_edge_lo_d;
      assign w_lo_v = w_edge_lo_v;
    end else begin : g_lo_mid
      assign w_lo_d = w_data[g-1];
      assign w_lo_v = w_vld_vec[g-1];
    end

    if (g == DEPTH-1) begin : g_hi_edge
      assign w_hi_d = w_edge_hi_d;
      assign w_hi_v = w_edge_hi_v;
    end else begin : g_hi_mid
      assign w_hi_d = w_data[g+1];
      assign w_hi_v = w_vld_vec[g+1];
    end

    shift_cell #(.WIDTH(WIDTH)) u_cell (
      .i_clk  (clk),
      .i_clr  (clr),
      .i_sel  (w_sel),
      .i_lo_d (w_lo_d),
      .i_lo_v (w_lo_v),
      .i_hi_d (w_hi_d),
      .i_hi_v (w_hi_v),
      .i_pin  (bus.pin[g*WIDTH +: WIDTH]),
      .o_d    (w_data[g]),
      .o_v    (w_vld_vec[g])
    );

    assign w_vld[g] = w_vld_vec[g];
    assign bus.pout[g*WIDTH +: WIDTH] = w_data[g];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_mode_err <= 1'b0;
    end else begin
      r_mode_err <= bus.en && (bus.mode == MODE_RSVD);
    end
  end

  assign bus.sout_r     = w_data[DEPTH-1];
  assign bus.sout_l     = w_data[0];
  assign bus.sout_r_vld = w_vld_vec[DEPTH-1];
  assign bus.sout_l_vld = w_vld_vec[0];
  assign bus.fill_cnt   = FILL_W'(popcount(MAX_DEPTH'(w_vld)));
  assign bus.full       = &w_vld;
  assign bus.empty      = ~|w_vld;
  assign bus.mode_err   = r_mode_err;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register, the next generation of the team's fixed 4-stage, 1-bit serial shifter. Provides DEPTH stages of WIDTH bits each, with right/left shift, rotate, parallel load and clear modes. A per-stage valid tag drives fill-level and full/empty status. Used as a serial-to-parallel / parallel-to-serial converter and as a fixed-latency delay line.

Parameters:
WIDTH, 1, bits per stage (>=1)
DEPTH, 4, number of stages (>=2)

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
en  in  1  operation enable; 0 = hold everything
mode  in  3  operation select (see Behaviour)
sin  in  WIDTH  serial data in
pin  in  DEPTH*WIDTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
sout_r  out  WIDTH  stage DEPTH-1 contents (right-shift exit)
sout_l  out  WIDTH  stage 0 contents (left-shift exit)
sout_r_vld  out  1  valid tag of stage DEPTH-1
sout_l_vld  out  1  valid tag of stage 0
pout  out  DEPTH*WIDTH  all stages, same packing as pin
fill_cnt  out  $clog2(DEPTH+1)  number of valid stages
full  out  1  fill_cnt == DEPTH
empty  out  1  fill_cnt == 0
mode_err  out  1  one-cycle pulse on reserved mode

Behaviour:
- Storage: stage[0..DEPTH-1] (WIDTH bits each) plus vld[0..DEPTH-1]. Everything updates on the rising clk edge only.
- Reset: clr=1 at an edge clears all stages, all vld bits and mode_err, regardless of en/mode. After reset: fill_cnt=0, empty=1, full=0, all outputs 0.
- clr has priority over en. A reset mid-operation discards all contents; there is no partial drain.
- en=0: state holds, and mode_err is forced to 0 on that edge.
- Modes (applied only when en=1):
  - 0 HOLD: no change.
  - 1 SHR: stage[0]<=sin, stage[i]<=stage[i-1], vld[0]<=1, vld shifts with the data. The old stage[DEPTH-1] is discarded.
  - 2 SHL: stage[DEPTH-1]<=sin, stage[i]<=stage[i+1], vld[DEPTH-1]<=1. The old stage[0] is discarded.
  - 3 ROTR: stage[0]<=stage[DEPTH-1], others as SHR. vld rotates identically; sin is ignored.
  - 4 ROTL: mirror image of ROTR.
  - 5 LOAD: stage[i]<=pin slice i, all vld<=1.
  - 6 CLEAR: stages and vld<=0 (same result as clr, but gated by en).
  - 7 reserved: acts as HOLD, and mode_err<=1 for one cycle. mode_err is otherwise 0 every cycle.
- Latency: in SHR with en held high, a value on sin at edge n appears on sout_r after edge n+DEPTH-1, i.e. it is the stage[DEPTH-1] register value following DEPTH edges. For DEPTH=4 this matches the legacy 4-flop chain timing. SHL has the same latency to sout_l.
- Outputs: all outputs are direct register outputs or decodes of registers; there is no combinational path from inputs.
- fill_cnt:
  - Always equals popcount(vld).
  - Saturates at DEPTH: a continued shift while full keeps it at DEPTH, with data overwritten and the oldest value dropped.
  - Rotates never change it.
  - A shift into an empty register gives 1.
- Width rules: pin/pout packing is little-endian by stage. There is no arithmetic on data; fill_cnt never wraps.

Decomposition:
- Package shift_pkg: mode encoding constants/enum (HOLD, SHR, SHL, ROTR, ROTL, LOAD, CLEAR, RSVD), popcount function, and the FILL_W = $clog2(DEPTH+1) helper.
- One sub-module, shift_cell: a single stage (data + vld flop) with a next-value mux selecting hold / left neighbour / right neighbour / pin slice / zero. Instantiated DEPTH times via generate, with edge wiring for rotate and serial-in done in the parent.

Test Plan:
- WIDTH=1, DEPTH=4:
  - clr=1 for 2 cycles, then en=1, mode=SHR, sin=1,0,1,1 -> sout_r=1 after the 4th edge. pout then reads stage0..3 = 1,1,0,1 (LSB first = 4'b1011). fill_cnt goes 1,2,3,4; full asserts after edge 4.
  - After the fill, 2 more SHR edges with sin=0 -> fill_cnt stays 4, full=1, and the oldest bits are dropped on sout_r.
- WIDTH=8, DEPTH=4:
  - LOAD pin=32'h44332211, then ROTR ×1 -> pout=32'h33221144, fill_cnt=4. ROTL ×1 -> 32'h44332211.
  - SHL ×2 from empty with sin=8'hAA, 8'hBB -> stage3=BB, stage2=AA, vld=4'b1100, fill_cnt=2, sout_l_vld=0.
- Control and error handling:
  - mode=7 with en=1 -> state unchanged, mode_err high for exactly one cycle. The same with en=0 -> mode_err stays 0.
  - clr=1 asserted on the same edge as LOAD with en=1 -> all zero, empty=1 (clr wins). en=0 with mode=SHR for 3 cycles -> pout unchanged.
